// File: rtl/load_store_unit_pkg.sv
// Shared funct3 encodings, FSM state type and the request fault rule
// for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE      = 1'b0,
    RMW_WRITE = 1'b1
  } lsu_state_t;

  // Unsigned widths exist only for loads, so BU/HU stores are illegal.
  function automatic logic lsu_fault(input logic store, input logic [2:0] f3,
                                     input logic [1:0] off);
    case (f3)
      F3_B:    lsu_fault = 1'b0;
      F3_H:    lsu_fault = off[0];
      F3_W:    lsu_fault = (off != 2'b00);
      F3_BU:   lsu_fault = store;
      F3_HU:   lsu_fault = store | off[0];
      default: lsu_fault = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [29:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_we, mem_wd
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_we, mem_wd
  );
endinterface

// File: rtl/lsu_load_align.sv
// Load lane select and sign/zero extension of a memory read word.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rd[{off, 3'b000} +: 8];
    lane_h = off[1] ? rd[31:16] : rd[15:0];
    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   data = {24'h0, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   data = {16'h0, lane_h};
      default: data = rd;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-port load/store unit: 1-cycle loads and SW, 2-cycle read-modify-write
// for SB/SH. States: IDLE = accept requests | RMW_WRITE = write merged word.
module load_store_unit
  import lsu_pkg::*;
(
  input logic             clk,
  input logic             reset,
  load_store_unit_if.slave bus
);

  lsu_state_t  state;
  logic [29:0] waddr_q;
  logic [31:0] merge_q;
  logic [31:0] merged;
  logic [31:0] load_data;
  logic [1:0]  off;
  logic        accept;
  logic        fault;
  logic        is_sw;

  assign off    = bus.req_addr[1:0];
  assign fault  = lsu_fault(bus.req_store, bus.req_funct3, off);
  assign accept = bus.req_valid & bus.req_ready;
  assign is_sw  = bus.req_store & (bus.req_funct3 == F3_W);

  assign bus.req_ready = (state == IDLE) & ~reset;
  assign bus.mem_addr  = (state == RMW_WRITE) ? waddr_q : bus.req_addr[31:2];
  assign bus.mem_wd    = (state == RMW_WRITE) ? merge_q : bus.req_wdata;
  // Reset kills a pending RMW write in the same cycle it is asserted.
  assign bus.mem_we    = ~reset & ((state == RMW_WRITE) | (accept & ~fault & is_sw));

  lsu_load_align u_align (
    .rd     (bus.mem_rd),
    .off    (off),
    .funct3 (bus.req_funct3),
    .data   (load_data)
  );

  always_comb begin
    merged = bus.mem_rd;
    if (bus.req_funct3 == F3_B)
      merged[{off, 3'b000} +: 8] = bus.req_wdata[7:0];
    else if (off[1])
      merged[31:16] = bus.req_wdata[15:0];
    else
      merged[15:0] = bus.req_wdata[15:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      waddr_q        <= '0;
      merge_q        <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_fault <= 1'b0;
      bus.resp_rdata <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_fault <= 1'b0;
      bus.resp_rdata <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (fault) begin
              bus.resp_valid <= 1'b1;
              bus.resp_fault <= 1'b1;
            end else if (!bus.req_store) begin
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= load_data;
            end else if (is_sw) begin
              bus.resp_valid <= 1'b1;
            end else begin
              waddr_q <= bus.req_addr[31:2];
              merge_q <= merged;
              state   <= RMW_WRITE;
            end
          end
        end
        RMW_WRITE: begin
          bus.resp_valid <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory and a
// response scoreboard.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [0:15];
  assign bus.mem_rd = mem[bus.mem_addr[3:0]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[3:0]] <= bus.mem_wd;

  int total = 0;
  int bad = 0;
  logic [32:0] exp_q [$];   // {fault, rdata}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got fault=%0b rdata=%08h, expected none",
                 bus.resp_fault, bus.resp_rdata);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("resp_fault", {31'h0, bus.resp_fault}, {31'h0, e[32]});
        check("resp_rdata", bus.resp_rdata, e[31:0]);
      end
    end
  end

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
  endtask

  task automatic idle_bus();
    bus.req_valid = 1'b0;
    bus.req_store = 1'b0;
    bus.req_funct3 = F3_W;
    bus.req_addr = '0;
    bus.req_wdata = '0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    idle_bus();
    drive(1'b1, F3_W, 32'h10, 32'h12345678);   // must be ignored under reset
    repeat (2) @(negedge clk);
    #1;
    check("reset_ready", {31'h0, bus.req_ready}, 32'h0);
    check("reset_we", {31'h0, bus.mem_we}, 32'h0);
    idle_bus();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_reset_ready", {31'h0, bus.req_ready}, 32'h1);
    check("post_reset_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("post_reset_we_idle", {31'h0, bus.mem_we}, 32'h0);

    // SW 0x10
    @(negedge clk);
    drive(1'b1, F3_W, 32'h10, 32'hDEADBEEF);
    exp_q.push_back({1'b0, 32'h0});
    #1;
    check("sw_we", {31'h0, bus.mem_we}, 32'h1);
    check("sw_addr", {2'b0, bus.mem_addr}, 32'h4);
    check("sw_wd", bus.mem_wd, 32'hDEADBEEF);

    // back-to-back loads LB, LBU, LHU
    @(negedge clk); drive(1'b0, F3_B,  32'h13, 32'h0); exp_q.push_back({1'b0, 32'hFFFFFFDE});
    @(negedge clk); drive(1'b0, F3_BU, 32'h13, 32'h0); exp_q.push_back({1'b0, 32'h000000DE});
    @(negedge clk); drive(1'b0, F3_HU, 32'h10, 32'h0); exp_q.push_back({1'b0, 32'h0000BEEF});

    // SB 0x11
    @(negedge clk);
    drive(1'b1, F3_B, 32'h11, 32'h000000AA);
    exp_q.push_back({1'b0, 32'h0});
    #1;
    check("sb_accept_we", {31'h0, bus.mem_we}, 32'h0);
    @(negedge clk);
    idle_bus();
    #1;
    check("sb_rmw_ready", {31'h0, bus.req_ready}, 32'h0);
    check("sb_rmw_we", {31'h0, bus.mem_we}, 32'h1);
    check("sb_rmw_wd", bus.mem_wd, 32'hDEADAAEF);
    check("sb_rmw_addr", {2'b0, bus.mem_addr}, 32'h4);
    @(negedge clk);
    check("sb_mem", mem[4], 32'hDEADAAEF);

    // faults: LW misaligned, SH misaligned, illegal load/store funct3
    @(negedge clk); drive(1'b0, F3_W,   32'h12, 32'h0);    exp_q.push_back({1'b1, 32'h0});
    #1; check("lw_mis_we", {31'h0, bus.mem_we}, 32'h0);
    @(negedge clk); drive(1'b1, F3_H,   32'h13, 32'hFFFF); exp_q.push_back({1'b1, 32'h0});
    #1; check("sh_mis_we", {31'h0, bus.mem_we}, 32'h0);
    @(negedge clk); drive(1'b0, 3'b011, 32'h10, 32'h0);    exp_q.push_back({1'b1, 32'h0});
    @(negedge clk); drive(1'b1, F3_BU,  32'h10, 32'h55);   exp_q.push_back({1'b1, 32'h0});
    #1; check("sbu_we", {31'h0, bus.mem_we}, 32'h0);
    @(negedge clk); drive(1'b1, F3_W,   32'h11, 32'h55);   exp_q.push_back({1'b1, 32'h0});
    #1; check("sw_mis_we", {31'h0, bus.mem_we}, 32'h0);

    // LH upper half sign extend, LW full word
    @(negedge clk); drive(1'b0, F3_H, 32'h12, 32'h0); exp_q.push_back({1'b0, 32'hFFFFDEAD});
    @(negedge clk); drive(1'b0, F3_W, 32'h10, 32'h0); exp_q.push_back({1'b0, 32'hDEADAAEF});
    @(negedge clk); idle_bus();
    #1; check("idle_no_we", {31'h0, bus.mem_we}, 32'h0);

    // SH upper lane into word 5
    @(negedge clk); drive(1'b1, F3_H, 32'h16, 32'hCAFEBABE); exp_q.push_back({1'b0, 32'h0});
    @(negedge clk); idle_bus();
    @(negedge clk);
    check("sh_mem", mem[5], 32'hBABE0000);

    // SH then reset during RMW_WRITE
    @(negedge clk); drive(1'b1, F3_H, 32'h10, 32'h00001234);
    @(negedge clk);
    idle_bus();
    reset = 1'b1;
    #1;
    check("rst_rmw_we", {31'h0, bus.mem_we}, 32'h0);
    check("rst_rmw_ready", {31'h0, bus.req_ready}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_rmw_ready_after", {31'h0, bus.req_ready}, 32'h1);
    check("rst_rmw_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("rst_rmw_mem", mem[4], 32'hDEADAAEF);

    // back-to-back SW then LW
    @(negedge clk); drive(1'b1, F3_W, 32'h0, 32'h11111111); exp_q.push_back({1'b0, 32'h0});
    @(negedge clk); drive(1'b1, F3_W, 32'h4, 32'h22222222); exp_q.push_back({1'b0, 32'h0});
    @(negedge clk); drive(1'b1, F3_W, 32'h8, 32'h33333333); exp_q.push_back({1'b0, 32'h0});
    @(negedge clk); drive(1'b0, F3_W, 32'h0, 32'h0); exp_q.push_back({1'b0, 32'h11111111});
    @(negedge clk); drive(1'b0, F3_W, 32'h4, 32'h0); exp_q.push_back({1'b0, 32'h22222222});
    @(negedge clk); drive(1'b0, F3_W, 32'h8, 32'h0); exp_q.push_back({1'b0, 32'h33333333});
    @(negedge clk); drive(1'b0, F3_W, 32'h14, 32'h0); exp_q.push_back({1'b0, 32'hBABE0000});
    @(negedge clk); idle_bus();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port req_valid, input, 1 bit: MEM-stage memory request present.
REQ-004 SHALL have port req_ready, output, 1 bit: request accepted this cycle when high together with req_valid.
REQ-005 SHALL have port req_store, input, 1 bit: 1 means store, 0 means load.
REQ-006 SHALL have port req_funct3, input, 3 bits: RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-007 SHALL have port req_addr, input, 32 bits: byte address.
REQ-008 SHALL have port req_wdata, input, 32 bits: store data, with the low byte or half used for SB/SH.
REQ-009 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata, output, 32 bits: extended load result, 0 for stores and faults.
REQ-011 SHALL have port resp_fault, output, 1 bit: misaligned or illegal funct3; valid with resp_valid.
REQ-012 SHALL have port mem_addr, output, 30 bits [31:2]: word address to the data memory.
REQ-013 SHALL have port mem_we, output, 1 bit: word write enable.
REQ-014 SHALL have port mem_wd, output, 32 bits: write word.
REQ-015 SHALL have port mem_rd, input, 32 bits: combinational read word for mem_addr.

Function
REQ-016 SHALL implement FSM states IDLE and RMW_WRITE; reset state is IDLE.
REQ-017 In IDLE, req_ready SHALL be 1; in RMW_WRITE, req_ready SHALL be 0.
REQ-018 In IDLE, mem_addr SHALL equal req_addr[31:2]; in RMW_WRITE, it SHALL equal the latched word address.
REQ-019 Alignment rule: a fault SHALL be raised for H/HU/SH when addr[0]=1, and for W/SW when addr[1:0]!=00.
REQ-020 Illegal-funct3 rule: a fault SHALL be raised for a load with funct3 011/110/111, and for a store with funct3 other than 000/001/010.
REQ-021 A faulting request SHALL be accepted, SHALL cause no memory write, and SHALL produce resp_valid=1, resp_fault=1, resp_rdata=0 on the next cycle.
REQ-022 Load: accepted in IDLE; on the next cycle, resp_valid=1 and resp_rdata SHALL hold the extracted, extended data registered from mem_rd; latency 1.
REQ-023 Load extraction: the byte lane SHALL be selected by addr[1:0] and the half lane by addr[1]. LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL pass the word.
REQ-024 SW: in the accept cycle, mem_we=1 and mem_wd=req_wdata; resp_valid=1 on the next cycle.
REQ-025 SB/SH, cycle 0 (IDLE accept): SHALL latch the word address and merge req_wdata's byte or half into mem_rd at the addressed lane. It SHALL go to RMW_WRITE with mem_we=0.
REQ-026 SB/SH, cycle 1 (RMW_WRITE): mem_we=1, mem_wd=merged word; SHALL return to IDLE; resp_valid=1 in cycle 2.
REQ-027 mem_we SHALL be 0 in all cases not named in REQ-024 and REQ-026.
REQ-028 resp_valid SHALL be a single-cycle pulse per accepted request; back-to-back loads/SW in consecutive cycles SHALL each complete.
REQ-029 req_valid=0 in IDLE SHALL produce no memory write and no response.

Reset
REQ-030 On reset=1 at a clock edge, the block SHALL go to IDLE with resp_valid=0, resp_fault=0, resp_rdata=0 and all latches cleared.
REQ-031 While reset=1, mem_we SHALL be 0, req_ready SHALL be 0, and requests SHALL be ignored.
REQ-032 Reset during RMW_WRITE SHALL abort the write (memory unchanged) and SHALL produce no response.

Structure
REQ-033 A shared package lsu_pkg SHALL hold the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the state enum lsu_state_t.
REQ-034 Combinational lane select and extension SHALL be a sub-module named lsu_load_align, instantiated once.

Verification
REQ-035 Reset, then SW addr 0x10, data 0xDEADBEEF -> mem_we=1, mem_addr=0x4 same cycle; resp_valid=1, fault=0 next cycle.
REQ-036 LB addr 0x13 with mem_rd=0xDEADBEEF -> resp_rdata=0xFFFFFFDE; LBU -> 0x000000DE; LHU addr 0x10 -> 0x0000BEEF.
REQ-037 SB addr 0x11, wdata 0x000000AA, mem_rd=0xDEADBEEF -> req_ready=0 next cycle, mem_we=1 with mem_wd=0xDEADAAEF, resp_valid in cycle 2.
REQ-038 LW addr 0x12; SH addr 0x13 -> resp_fault=1, resp_rdata=0, mem_we never asserted.
REQ-039 SH accepted, reset asserted in RMW_WRITE -> mem_we=0, no resp_valid, IDLE and req_ready=1 after reset is released.
REQ-040 Three back-to-back LW requests -> three consecutive resp_valid pulses with the matching data.
